// File: rtl/alu_seq.sv
// alu_seq: registered datapath ALU with a valid/ready handshake.
// Supports ADD, SUB, AND, NOT B, SHL, LSR, ASR and, when ALU_SEQ_MUL_EN is
// defined, an iterative shift-add multiplier (op 111). Without
// ALU_SEQ_MUL_EN, op 111 completes in one cycle and is flagged unsupported
// (ALU_out=0, Z=1, N=0, V=1). Only one operation is in flight at a time.
module alu_seq #(
  parameter int WIDTH   = 16,
  // Derived from WIDTH; leave at its default.
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  input  logic [2:0]       ALU_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_e;
`endif

  state_e state;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;

  assign shamt = val_B[SHAMT_W-1:0];

  // Single-cycle result and overflow flag for every op, computed from the live inputs at the accept edge
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        alu_res = val_A + val_B;
        alu_v   = (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != val_A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = val_A - val_B;
        alu_v   = (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != val_A[WIDTH-1]);
      end
      OP_AND:  alu_res = val_A & val_B;
      OP_NOTB: alu_res = ~val_B;
      OP_SHL:  alu_res = val_A << shamt;
      OP_LSR:  alu_res = val_A >> shamt;
      OP_ASR:  alu_res = $signed(val_A) >>> shamt;
      OP_MUL: begin
        alu_res = '0;
        alu_v   = 1'b1;
      end
      default: begin
        alu_res = '0;
        alu_v   = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     partial;
  logic [SHAMT_W-1:0] count;

  // One shift-add step: the low product bit is the current multiplier bit; add the multiplicand into the upper half, then shift right
  always_comb begin
    partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {partial, prod[WIDTH-1:1]};
  end
`endif

  // Control FSM with registered handshake, result and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALU_out   <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand     <= '0;
      prod      <= '0;
      count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (ALU_op == OP_MUL) begin
              mcand <= val_A;
              prod  <= {{WIDTH{1'b0}}, val_B};
              count <= '0;
              state <= MUL;
            end else begin
              ALU_out   <= alu_res;
              Z         <= (alu_res == '0);
              N         <= alu_res[WIDTH-1];
              V         <= alu_v;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            ALU_out   <= alu_res;
            Z         <= (alu_res == '0);
            N         <= alu_res[WIDTH-1];
            V         <= alu_v;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          prod  <= prod_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            ALU_out   <= prod_next[WIDTH-1:0];
            Z         <= (prod_next[WIDTH-1:0] == '0);
            N         <= prod_next[WIDTH-1];
            V         <= |prod_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16) using a scoreboard
// of expected results filled when an operation is accepted.
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] val_A;
  logic [15:0] val_B;
  logic [2:0]  ALU_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ALU_out;
  logic        Z;
  logic        N;
  logic        V;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .val_A(val_A),
    .val_B(val_B),
    .ALU_op(ALU_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALU_out(ALU_out),
    .Z(Z),
    .N(N),
    .V(V)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model built from wide signed/unsigned arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t        e;
    int          sa;
    int          sbv;
    int          full;
    logic [31:0] p;
    logic [3:0]  amt;
    amt   = b[3:0];
    e.res = '0;
    e.v   = 1'b0;
    e.lat = 1;
    e.tag = "";
    sa    = $signed(a);
    sbv   = $signed(b);
    case (op)
      3'd0: begin
        full  = sa + sbv;
        e.res = full[15:0];
        e.v   = (full > 32767) || (full < -32768);
      end
      3'd1: begin
        full  = sa - sbv;
        e.res = full[15:0];
        e.v   = (full > 32767) || (full < -32768);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = ~b;
      3'd4: begin
        p     = {16'h0000, a} << amt;
        e.res = p[15:0];
      end
      3'd5: e.res = a >> amt;
      3'd6: begin
        full  = sa >>> amt;
        e.res = full[15:0];
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p     = {16'h0000, a} * {16'h0000, b};
        e.res = p[15:0];
        e.v   = (p[31:16] != 16'h0000);
        e.lat = 17;
`else
        e.res = 16'h0000;
        e.v   = 1'b1;
        e.lat = 1;
`endif
      end
    endcase
    e.z = (e.res == 16'h0000);
    e.n = e.res[15];
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one request, let it be accepted, then scramble the inputs
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input string tag);
    exp_t e;
    checkValue({tag, " in_ready before accept"}, 32'(in_ready), 32'(1'b1));
    ALU_op   = op;
    val_A    = a;
    val_B    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALU_op   = ~op;
    val_A    = 16'hDEAD;
    val_B    = 16'hBEEF;
    e        = model(op, a, b);
    e.tag    = tag;
    sb.push_back(e);
    checkValue({tag, " in_ready busy"}, 32'(in_ready), 32'(1'b0));
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head
  task automatic checkOutput();
    exp_t e;
    int   cyc;
    e   = sb.pop_front();
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkValue({e.tag, " latency"}, 32'(cyc + 1), 32'(e.lat));
    checkValue({e.tag, " ALU_out"}, 32'(ALU_out), 32'(e.res));
    checkValue({e.tag, " Z"}, 32'(Z), 32'(e.z));
    checkValue({e.tag, " N"}, 32'(N), 32'(e.n));
    checkValue({e.tag, " V"}, 32'(V), 32'(e.v));
  endtask

  // Accept the result and confirm the block is back in IDLE
  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkValue("release in_ready", 32'(in_ready), 32'(1'b1));
    checkValue("release out_valid", 32'(out_valid), 32'(1'b0));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    val_A     = '0;
    val_B     = '0;
    ALU_op    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset in_ready", 32'(in_ready), 32'(1'b1));
    checkValue("reset out_valid", 32'(out_valid), 32'(1'b0));
    checkValue("reset ALU_out", 32'(ALU_out), 32'(16'h0000));
    checkValue("reset Z", 32'(Z), 32'(1'b0));
    checkValue("reset N", 32'(N), 32'(1'b0));
    checkValue("reset V", 32'(V), 32'(1'b0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(3'd0, 16'h7FFF, 16'h0001, "add ovf");   checkOutput(); releaseResult();
    applyStimulus(3'd1, 16'h1234, 16'h1234, "sub zero");  checkOutput(); releaseResult();
    applyStimulus(3'd1, 16'h8000, 16'h0001, "sub ovf");   checkOutput(); releaseResult();
    applyStimulus(3'd2, 16'hA5A5, 16'h0FF0, "and");       checkOutput(); releaseResult();
    applyStimulus(3'd3, 16'h1234, 16'h00FF, "not b");     checkOutput(); releaseResult();
    applyStimulus(3'd4, 16'h0001, 16'h123F, "shl 15");    checkOutput(); releaseResult();
    applyStimulus(3'd5, 16'h8000, 16'h0004, "lsr 4");     checkOutput(); releaseResult();
    applyStimulus(3'd6, 16'h8000, 16'h0004, "asr 4");     checkOutput(); releaseResult();
    applyStimulus(3'd6, 16'h8001, 16'hFFF0, "asr 0");     checkOutput(); releaseResult();
    applyStimulus(3'd7, 16'h0012, 16'h0034, "mul small"); checkOutput(); releaseResult();
    applyStimulus(3'd7, 16'h0100, 16'h0100, "mul ovf");   checkOutput(); releaseResult();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), "random");
      checkOutput();
      releaseResult();
    end

    // Backpressure: result held for 5 cycles while a competing request is offered
    applyStimulus(3'd0, 16'h1111, 16'h2222, "bp add");
    checkOutput();
    for (int i = 0; i < 5; i++) begin
      ALU_op   = 3'd0;
      val_A    = 16'h0100;
      val_B    = 16'h0200;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkValue("bp out_valid", 32'(out_valid), 32'(1'b1));
      checkValue("bp ALU_out", 32'(ALU_out), 32'(16'h3333));
      checkValue("bp flags", 32'({Z, N, V}), 32'(3'b000));
      checkValue("bp in_ready", 32'(in_ready), 32'(1'b0));
    end
    in_valid = 1'b0;
    releaseResult();
    @(posedge clk);
    #1;
    checkValue("bp ignored req", 32'(out_valid), 32'(1'b0));

    // Reset while op 111 is in progress (or held in DONE without the multiplier)
    applyStimulus(3'd7, 16'h0012, 16'h0034, "rst op");
    sb.delete(sb.size() - 1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkValue("mid reset in_ready", 32'(in_ready), 32'(1'b1));
    checkValue("mid reset out_valid", 32'(out_valid), 32'(1'b0));
    checkValue("mid reset ALU_out", 32'(ALU_out), 32'(16'h0000));
    checkValue("mid reset flags", 32'({Z, N, V}), 32'(3'b000));
    @(posedge clk);
    #1;
    checkValue("post reset out_valid", 32'(out_valid), 32'(1'b0));

    applyStimulus(3'd0, 16'h0003, 16'h0004, "add after reset");
    checkOutput();
    releaseResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
